// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating wait counter for the ISSUE state; expired flags the last allowed cycle.
module arb_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holds at LAST instead of wrapping so a stalled ISSUE can never re-arm.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
//   state | meaning
//   IDLE  | wait for a request, latch the winner's address/data/we
//   ISSUE | drive mem_req with latched values until mem_ready or timeout
//   RESP  | done pulse visible, last_grant updated, back to IDLE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            ls_req,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic            ls_we,
  output logic            if_done,
  output logic            ls_done,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_sel,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  arb_state_e      state_q;
  logic            grant_q, last_grant_q;
  logic            mem_req_q, mem_we_q, if_done_q, ls_done_q, err_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic            win_ls, expired;

  // LS wins when alone, or when both ask and IF was served last.
  assign win_ls = ls_req && (!if_req || (last_grant_q == GNT_IF));

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ISSUE),
    .en      (state_q == ISSUE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_IF;
      last_grant_q <= GNT_LS;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || ls_req) begin
            grant_q   <= win_ls ? GNT_LS : GNT_IF;
            addr_q    <= win_ls ? ls_addr : if_addr;
            wdata_q   <= win_ls ? ls_wdata : '0;
            mem_we_q  <= win_ls && ls_we;
            mem_req_q <= 1'b1;
            err_q     <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          // A response on the final allowed cycle still counts as success.
          if (mem_ready || expired) begin
            mem_req_q <= 1'b0;
            err_q     <= !mem_ready;
            rdata_q   <= mem_ready ? mem_rdata : '0;
            if_done_q <= (grant_q == GNT_IF);
            ls_done_q <= (grant_q == GNT_LS);
            state_q   <= RESP;
          end
        end
        RESP: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an expected-transaction queue.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst, if_req, ls_req, ls_we, mem_ready;
  logic [XLEN-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic            if_done, ls_done, err, mem_req, mem_we, mem_sel;
  logic [XLEN-1:0] rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_we     (ls_we),
    .if_done   (if_done),
    .ls_done   (ls_done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // delay < 0 means mem_ready is never given (timeout expected)
  typedef struct {
    logic            ls;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [XLEN-1:0] mrd;
    int              delay;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic ls, input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                      input logic we, input logic [XLEN-1:0] mrd, input int delay);
    exp_t e;
    e.ls = ls; e.addr = addr; e.wdata = wdata; e.we = we; e.mrd = mrd; e.delay = delay;
    sb.push_back(e);
  endtask

  // Serve the next queued transaction: wait for mem_req, answer after e.delay ISSUE cycles.
  task automatic serve(input bit keep, input int lat);
    exp_t e;
    int   n;
    int   issue_cycles;
    logic done_seen;
    chk("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n = 0;
    while (!mem_req && n < 20) begin
      tick;
      n++;
    end
    chk("mem_req_rise", mem_req, 1);
    if (lat >= 0) chk("req_latency", n, lat);
    chk("mem_sel_issue", mem_sel, e.ls ? GNT_LS : GNT_IF);
    issue_cycles = 1;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk("mem_addr_stable", mem_addr, e.addr);
      chk("mem_we_stable", mem_we, e.ls && e.we);
      if (e.ls) chk("mem_wdata_stable", mem_wdata, e.wdata);
      if (e.delay >= 0 && c == e.delay) begin
        mem_ready = 1'b1;
        mem_rdata = e.mrd;
      end
      tick;
      mem_ready = 1'b0;
      if (if_done || ls_done) begin
        done_seen = 1'b1;
        break;
      end
      issue_cycles++;
      chk("mem_req_hold", mem_req, 1);
    end
    chk("done_seen", done_seen, 1);
    chk("if_done", if_done, !e.ls);
    chk("ls_done", ls_done, e.ls);
    chk("err", err, (e.delay < 0));
    chk("rdata", rdata, (e.delay < 0) ? '0 : e.mrd);
    chk("mem_sel_resp", mem_sel, e.ls ? GNT_LS : GNT_IF);
    chk("mem_req_resp", mem_req, 0);
    chk("issue_cycles", issue_cycles, (e.delay < 0) ? TIMEOUT : e.delay + 1);
    if (!keep) begin
      if (e.ls) ls_req = 1'b0;
      else      if_req = 1'b0;
    end
    tick;
    chk("done_one_pulse", (if_done | ls_done), 0);
    chk("mem_sel_hold", mem_sel, e.ls ? GNT_LS : GNT_IF);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = 32'hCAFEF00D;
    tick; tick;
    rst = 1'b0;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);

    // mem_ready while idle has no effect
    mem_ready = 1'b1;
    tick; tick;
    chk("idle_ready_req", mem_req, 0);
    chk("idle_ready_done", (if_done | ls_done), 0);
    chk("idle_ready_rdata", rdata, 0);
    mem_ready = 1'b0;

    // simultaneous requests after reset: IF first, then LS
    if_addr = 32'h40; ls_addr = 32'h80; ls_wdata = 32'h11; ls_we = 1'b0;
    push(1'b0, 32'h40, 32'h0, 1'b0, 32'hA1A1A1A1, 0);
    push(1'b1, 32'h80, 32'h11, 1'b0, 32'hB2B2B2B2, 0);
    if_req = 1'b1; ls_req = 1'b1;
    serve(1'b0, 1);
    serve(1'b0, 1);

    // both held: IF, LS, IF, LS
    if_addr = 32'h200; ls_addr = 32'h300; ls_wdata = 32'h5555; ls_we = 1'b1;
    push(1'b0, 32'h200, 32'h0,    1'b0, 32'h0000_1001, 0);
    push(1'b1, 32'h300, 32'h5555, 1'b1, 32'h0000_2002, 1);
    push(1'b0, 32'h200, 32'h0,    1'b0, 32'h0000_3003, 2);
    push(1'b1, 32'h300, 32'h5555, 1'b1, 32'h0000_4004, 0);
    if_req = 1'b1; ls_req = 1'b1;
    serve(1'b1, 1);
    serve(1'b1, 1);
    serve(1'b1, 1);
    serve(1'b1, 1);
    if_req = 1'b0; ls_req = 1'b0;

    // store with delayed ready; requester inputs change during ISSUE
    ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF; ls_we = 1'b1;
    push(1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0BADCAFE, 3);
    ls_req = 1'b1;
    tick;
    ls_addr = 32'h999; ls_wdata = 32'h0; ls_we = 1'b0;
    serve(1'b0, 0);

    // fetch with no response: timeout
    mem_rdata = 32'hCAFEF00D;
    if_addr = 32'h444;
    push(1'b0, 32'h444, 32'h0, 1'b0, 32'hCAFEF00D, -1);
    if_req = 1'b1;
    serve(1'b0, 1);

    // request dropped mid-transaction still completes
    if_addr = 32'h88;
    push(1'b0, 32'h88, 32'h0, 1'b0, 32'h7777_8888, 2);
    if_req = 1'b1;
    tick;
    if_req = 1'b0;
    serve(1'b0, 0);

    // reset during ISSUE
    if_addr = 32'h600;
    if_req = 1'b1;
    tick;
    chk("pre_rst_mem_req", mem_req, 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; if_req = 1'b0;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_done", (if_done | ls_done), 0);
    chk("midrst_mem_sel", mem_sel, 0);
    chk("midrst_err", err, 0);
    tick; tick;
    chk("midrst_idle_req", mem_req, 0);
    chk("midrst_idle_done", (if_done | ls_done), 0);

    // after reset IF wins contention again
    if_addr = 32'h700; ls_addr = 32'h704; ls_wdata = 32'h0; ls_we = 1'b0;
    push(1'b0, 32'h700, 32'h0, 1'b0, 32'h12345678, 0);
    push(1'b1, 32'h704, 32'h0, 1'b0, 32'h9ABCDEF0, 0);
    if_req = 1'b1; ls_req = 1'b1;
    serve(1'b0, 1);
    serve(1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
